// File: rtl/rmst_ctrl.sv
// rmst_ctrl: splits a load into FIFO-gated tiles and sequences the Avalon read engine per tile
module rmst_ctrl #(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int DATA_SIZE = 1024,
  parameter int TILE_LEN  = 128,
  parameter int CW        = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_start,
  input  logic [DW-1:0] load_base_addr,
  output logic          load_done,
  output logic          busy,
  output logic [DW-1:0] param_raddr,
  output logic [AW-1:0] param_iolen,
  output logic          load_trans_start,
  input  logic          load_trans_done,
  input  logic [CW-1:0] load_fifo_space
);
  localparam int RW = $clog2(DATA_SIZE + 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CONFIG, S_TRANS, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] remaining_q, remaining_d;
  logic [DW-1:0] raddr_q, raddr_d;
  logic [AW-1:0] iolen_q, iolen_d, tile;
  logic          trans_start_q, trans_start_d, done_q, done_d;
  logic          accept_start, accept_done, space_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      remaining_q   <= '0;
      raddr_q       <= '0;
      iolen_q       <= '0;
      trans_start_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      raddr_q       <= raddr_d;
      iolen_q       <= iolen_d;
      trans_start_q <= trans_start_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    tile     = (32'(remaining_q) < 32'(TILE_LEN)) ? AW'(remaining_q) : AW'(TILE_LEN);
    space_ok = 32'(load_fifo_space) >= 32'(tile);
    state_d  = state_q;
    case (state_q)
      S_IDLE:   if (load_start) state_d = S_WAIT;
      S_WAIT:   if (space_ok) state_d = S_CONFIG;
      S_CONFIG: state_d = S_TRANS;
      S_TRANS:  if (load_trans_done) state_d = S_DONE;
      S_DONE:   state_d = (remaining_q == '0) ? S_IDLE : S_WAIT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Address and remaining count advance by the tile just received, on the done edge.
  always_comb begin
    accept_start  = (state_q == S_IDLE) && load_start;
    accept_done   = (state_q == S_TRANS) && load_trans_done;
    raddr_d       = accept_start ? load_base_addr
                  : accept_done  ? raddr_q + (DW'(iolen_q) << 2) : raddr_q;
    remaining_d   = accept_start ? RW'(DATA_SIZE)
                  : accept_done  ? remaining_q - RW'(iolen_q) : remaining_q;
    iolen_d       = (state_q == S_CONFIG) ? tile : iolen_q;
    trans_start_d = state_q == S_CONFIG;
    done_d        = (state_q == S_DONE) && (remaining_q == '0);
  end

  assign load_done        = done_q;
  assign busy             = state_q != S_IDLE;
  assign param_raddr      = raddr_q;
  assign param_iolen      = iolen_q;
  assign load_trans_start = trans_start_q;
endmodule
